// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver.
//   SEG_0..SEG_9, SEG_OFF : segment codes, bit order {dp,a,b,c,d,e,f,g}, high active
//   conv_state_t          : binary-to-BCD converter FSM states
//   max_val()             : largest value representable in a given number of digits
//   seg_decode()          : BCD nibble to segment code (non-decimal nibbles blank)
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_0   = 8'h7E;
  localparam logic [7:0] SEG_1   = 8'h30;
  localparam logic [7:0] SEG_2   = 8'h6D;
  localparam logic [7:0] SEG_3   = 8'h79;
  localparam logic [7:0] SEG_4   = 8'h33;
  localparam logic [7:0] SEG_5   = 8'h5B;
  localparam logic [7:0] SEG_6   = 8'h5F;
  localparam logic [7:0] SEG_7   = 8'h70;
  localparam logic [7:0] SEG_8   = 8'h7F;
  localparam logic [7:0] SEG_9   = 8'h7B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // 10^num_digits - 1
  function automatic logic [63:0] max_val(input int unsigned num_digits);
    logic [63:0] m;
    m = 64'd1;
    for (int unsigned i = 0; i < num_digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted in IDLE or COMMIT; captures bin and begins conversion
//   bin        : binary input (must fit in NUM_DIGITS decimal digits)
//   busy       : high in CONV and COMMIT
//   done       : high for the single COMMIT cycle; bcd is valid then
//   bcd        : NUM_DIGITS packed BCD nibbles, least significant digit in [3:0]
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned VAL_W      = 27,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned SR_W  = BCD_W + VAL_W;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  conv_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SR_W-1:0]  sreg, sreg_d, adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sreg  <= sreg_d;
    end
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    adj = sreg;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sreg[VAL_W+4*i +: 4] >= 4'd5)
        adj[VAL_W+4*i +: 4] = sreg[VAL_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        if (state == ST_COMMIT) state_d = ST_IDLE;
        if (start) begin
          sreg_d            = '0;
          sreg_d[VAL_W-1:0] = bin;
          cnt_d             = '0;
          state_d           = ST_CONV;
        end
      end
      ST_CONV: begin
        sreg_d = {adj[SR_W-2:0], 1'b0};
        cnt_d  = cnt + 1'b1;
        if (cnt == CNT_W'(VAL_W - 1)) state_d = ST_COMMIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_COMMIT);
  assign bcd  = sreg[VAL_W +: BCD_W];

endmodule

// File: rtl/seg_mux_driver.sv
// Multiplexed 1..8 digit 7-segment driver with sequential BCD conversion,
// saturation, leading-zero blanking and inter-digit ghost blanking.
//   clk, rst_n : system clock, asynchronous active-low reset
//   value      : unsigned binary value, captured on load
//   load       : one-cycle strobe; a load while busy is held as pending (latest wins)
//   dp_pos     : (SEG_DP_EN only) digit index carrying the decimal point,
//                NUM_DIGITS = none; sampled when a conversion commits
//   busy       : conversion in progress
//   an         : anode selects, one-hot or zero; an[0] is the most significant digit
//   seg0/seg1  : segment buses for an[0..3] / an[4..7], {dp,a,b,c,d,e,f,g}
// Optional feature macro: SEG_DP_EN (decimal point support).
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned VAL_W      = 27,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [VAL_W-1:0]                  value,
  input  logic                              load,
`ifdef SEG_DP_EN
  input  logic [$clog2(NUM_DIGITS+1)-1:0]   dp_pos,
`endif
  output logic                              busy,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [7:0]                        seg0,
  output logic [7:0]                        seg1
);

  localparam logic [63:0] MAXV   = max_val(NUM_DIGITS);
  localparam bit          SAT_EN = ((64'd1 << VAL_W) - 64'd1) > MAXV;
  localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    conv_start, conv_busy, conv_done;
  logic [VAL_W-1:0]        start_raw, conv_in;
  logic [4*NUM_DIGITS-1:0] conv_bcd, disp_q;
  logic                    pend_q;
  logic [VAL_W-1:0]        pend_val_q;
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [7:0]              digit_code, seg0_d, seg1_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [3:0]              nib;
  logic                    seen, dp_here;
`ifdef SEG_DP_EN
  logic [$clog2(NUM_DIGITS+1)-1:0] dp_q;
`endif

  function automatic logic [VAL_W-1:0] saturate(input logic [VAL_W-1:0] v);
    if (SAT_EN && (64'(v) > MAXV)) return VAL_W'(MAXV);
    return v;
  endfunction

  // A load landing on the COMMIT cycle is taken straight into the converter,
  // which is the same outcome as parking it in the pending register first.
  assign conv_start = (load & ~conv_busy) | (conv_done & (load | pend_q));
  assign start_raw  = (conv_done & ~load) ? pend_val_q : value;
  assign conv_in    = saturate(start_raw);
  assign busy       = conv_busy;

  bin2bcd_seq #(
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
`ifdef SEG_DP_EN
      dp_q       <= ($clog2(NUM_DIGITS+1))'(NUM_DIGITS);
`endif
    end else begin
      if (conv_done) begin
        pend_q <= 1'b0;
      end else if (load && conv_busy) begin
        pend_q     <= 1'b1;
        pend_val_q <= value;
      end
      if (conv_done) begin
        disp_q <= conv_bcd;
`ifdef SEG_DP_EN
        dp_q   <= dp_pos;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (32'(presc) == SCAN_DIV - 1) begin
      presc <= '0;
      idx   <= (32'(idx) == NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Walk from the most significant digit; once a non-zero digit (or the dp
  // digit, or the last digit) is reached, every following digit is shown.
  always_comb begin
    digit_code = SEG_OFF;
    seen       = 1'b0;
    nib        = '0;
    dp_here    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib = disp_q[4*(NUM_DIGITS-1-i) +: 4];
`ifdef SEG_DP_EN
      dp_here = (i == 32'(dp_q));
`endif
      if (nib != 4'd0 || i == NUM_DIGITS - 1 || dp_here) seen = 1'b1;
      if (i == 32'(idx)) begin
        digit_code    = seen ? seg_decode(nib) : SEG_OFF;
        digit_code[7] = dp_here;
      end
    end
  end

  always_comb begin
    an_d   = '0;
    seg0_d = SEG_OFF;
    seg1_d = SEG_OFF;
    if (32'(presc) >= BLANK_CYC) begin
      an_d[idx] = 1'b1;
      if (32'(idx) < 4) seg0_d = digit_code;
      else              seg1_d = digit_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= '0;
      seg0 <= SEG_OFF;
      seg1 <= SEG_OFF;
    end else begin
      an   <= an_d;
      seg0 <= seg0_d;
      seg1 <= seg1_d;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Scoreboard bench for seg_mux_driver (8 digits, 27-bit value, short scan slot).
// Stimulus pushes the expected final display value; a monitor process pops it
// once the converter is idle and checks one full scan frame against a
// division-based decimal model.
`timescale 1ns/1ps
module tb_seg_mux_driver;

  localparam int N   = 8;
  localparam int VW  = 27;
  localparam int SD  = 10;
  localparam int BC  = 2;
  localparam int DPW = $clog2(N + 1);

  localparam logic [7:0] DEC [0:9] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                                       8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy;
  logic [N-1:0]  an;
  logic [7:0]    seg0, seg1;
  int            dp_sel = N;

`ifdef SEG_DP_EN
  logic [DPW-1:0] dp_pos;
  assign dp_pos = DPW'(dp_sel);
`endif

  seg_mux_driver #(
    .NUM_DIGITS (N),
    .VAL_W      (VW),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .value  (value),
    .load   (load),
`ifdef SEG_DP_EN
    .dp_pos (dp_pos),
`endif
    .busy   (busy),
    .an     (an),
    .seg0   (seg0),
    .seg1   (seg1)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned v;
    int              dp;
  } exp_t;

  exp_t            exp_q[$];
  int              tests = 0;
  int              fails = 0;
  int              frames_done = 0;
  longint unsigned bq[$];
  int              bg[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected segment code of digit i (0 = most significant) from decimal arithmetic.
  function automatic logic [7:0] exp_code(input longint unsigned v, input int i, input int dp);
    longint unsigned maxv, w, sv;
    logic [7:0]      c;
    maxv = 1;
    for (int k = 0; k < N; k++) maxv = maxv * 10;
    maxv = maxv - 1;
    sv = (v > maxv) ? maxv : v;
    w = 1;
    for (int k = 0; k < N - 1 - i; k++) w = w * 10;
    c = 8'h00;
    if (sv >= w || i == N - 1 || i >= dp) c = DEC[int'((sv / w) % 10)];
    if (i == dp) c[7] = 1'b1;
    return c;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] a);
    if (!$onehot(a)) return -1;
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic check_frame(input longint unsigned v, input int dp);
    logic [N-1:0] prev, slot_an;
    logic [7:0]   want, first_code, cur, other;
    int           guard, first, ci, vis, blank, bad;
    bit           synced;
    prev = an; synced = 1'b0; guard = 0;
    while (!synced && guard < 3 * SD) begin
      @(negedge clk);
      guard++;
      synced = (prev == '0) && (an != '0);
      prev = an;
    end
    chk("frame_sync", synced, 1);
    if (!synced) return;
    first = onehot_idx(an);
    for (int s = 0; s < N; s++) begin
      ci = onehot_idx(an);
      chk($sformatf("slot%0d_index", s), longint'(ci), longint'((first + s) % N));
      if (ci < 0) return;
      want = exp_code(v, ci, dp);
      first_code = (ci < 4) ? seg0 : seg1;
      slot_an = an; vis = 0; bad = 0;
      while (an == slot_an && vis < SD) begin
        cur   = (ci < 4) ? seg0 : seg1;
        other = (ci < 4) ? seg1 : seg0;
        if (cur != first_code || other != 8'h00) bad++;
        vis++;
        @(negedge clk);
      end
      chk($sformatf("digit%0d_seg", ci), first_code, want);
      chk($sformatf("digit%0d_stable", ci), bad, 0);
      chk($sformatf("digit%0d_visible_len", ci), vis, SD - BC);
      blank = 0; bad = 0;
      while (an == '0 && blank < SD) begin
        if (seg0 != 8'h00 || seg1 != 8'h00) bad++;
        blank++;
        @(negedge clk);
      end
      chk($sformatf("gap_after_digit%0d_len", ci), blank, BC);
      chk($sformatf("gap_after_digit%0d_seg", ci), bad, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !busy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_frame(e.v, e.dp);
        frames_done++;
      end
    end
  end

  task automatic expect_frame(input longint unsigned v, input int dp);
    exp_t e;
    int   target, guard;
    e.v = v; e.dp = dp;
    target = frames_done + 1;
    exp_q.push_back(e);
    guard = 0;
    while (frames_done < target && guard < 20 * SD * N) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_timeout", frames_done >= target, 1);
    if (frames_done < target) exp_q.delete();
  endtask

  task automatic do_load(input longint unsigned v);
    @(posedge clk); #1;
    value = VW'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 8 * VW) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic single(input longint unsigned v, input int dp);
    int n;
    dp_sel = dp;
    do_load(v);
    wait_idle(n);
    chk($sformatf("busy_len_%0d", v), (n >= VW && n <= VW + 1), 1);
    expect_frame(v, dp);
  endtask

  // Loads every value in bq; bg holds the capture-to-capture spacing (>= 2).
  task automatic run_burst();
    int              n;
    longint unsigned last;
    last = 0;
    for (int k = 0; k < bq.size(); k++) begin
      if (k > 0) repeat (bg[k-1] - 2) @(posedge clk);
      do_load(bq[k]);
      last = bq[k];
    end
    wait_idle(n);
    chk("burst_idle", busy, 0);
    expect_frame(last, dp_sel);
  endtask

  initial begin : stim
    longint unsigned v;
    int              n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", an, 0);
    chk("reset_seg0", seg0, 0);
    chk("reset_seg1", seg1, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_frame(0, N);

    single(12345678, N);

    bq = '{99, 5}; bg = '{3};
    run_burst();

    single(134217727, N);
    single(100000000, N);
    single(99999999, N);
    single(10000000, N);
    single(0, N);
    single(7, N);

    for (int r = 0; r < 6; r++) begin
      v = longint'($urandom()) & ((64'd1 << VW) - 1);
      v = v >> $urandom_range(0, VW - 1);
      single(v, N);
    end

    for (int r = 0; r < 3; r++) begin
      bq.delete(); bg.delete();
      for (int k = 0; k < 3; k++) begin
        bq.push_back(longint'($urandom_range(0, (1 << VW) - 1)) >> $urandom_range(0, 20));
        bg.push_back($urandom_range(2, VW + 3));
      end
      run_burst();
    end

`ifdef SEG_DP_EN
    single(5, 6);
    single(1234, 3);
    single(42, N - 1);
    dp_sel = N;
`endif

    do_load(55555555);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_an", an, 0);
    chk("midreset_seg0", seg0, 0);
    chk("midreset_seg1", seg1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle(n);
    expect_frame(0, N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
